// File: rtl/ped_debounce.sv
// Pedestrian push-button front end: consecutive-sample debounce of an
// already-synchronized button level, press pulse, sticky request with
// acknowledge, overrun flag and a saturating press counter.
//
// Ports:
//   clk          block clock (same domain as the upstream synchronizer)
//   rst_n        asynchronous active-low reset
//   btn_sync     synchronized button level, 1 = pressed
//   ped_ack      controller acknowledge, clears ped_req
//   btn_level    debounced button level
//   btn_press    one-cycle pulse per accepted press
//   ped_req      sticky pedestrian request
//   overrun      one-cycle pulse: press accepted while a request is still pending
//   press_count  saturating count of accepted presses
module ped_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_sync,
    input  logic             ped_ack,
    output logic             btn_level,
    output logic             btn_press,
    output logic             ped_req,
    output logic             overrun,
    output logic [CNT_W-1:0] press_count
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]    LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHECK_HI  = 2'd1,
        STABLE_HI = 2'd2,
        CHECK_LO  = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          press_accept_c;

    // A press is accepted on the edge that sees the Nth consecutive high sample.
    assign press_accept_c = (state == CHECK_HI) && btn_sync && (cnt == LAST);

    // Debounce FSM with registered level and press pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= STABLE_LO;
            cnt       <= '0;
            btn_level <= 1'b0;
            btn_press <= 1'b0;
        end else begin
            btn_press <= 1'b0;
            case (state)
                STABLE_LO: begin
                    if (btn_sync) begin
                        state <= CHECK_HI;
                        cnt   <= CW'(1);
                    end
                end
                CHECK_HI: begin
                    if (!btn_sync) begin
                        state <= STABLE_LO;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state     <= STABLE_HI;
                        cnt       <= '0;
                        btn_level <= 1'b1;
                        btn_press <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STABLE_HI: begin
                    if (!btn_sync) begin
                        state <= CHECK_LO;
                        cnt   <= CW'(1);
                    end
                end
                CHECK_LO: begin
                    if (btn_sync) begin
                        state <= STABLE_HI;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state     <= STABLE_LO;
                        cnt       <= '0;
                        btn_level <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= STABLE_LO;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Request latch: a new press wins over an ack landing on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ped_req     <= 1'b0;
            overrun     <= 1'b0;
            press_count <= '0;
        end else begin
            overrun <= 1'b0;
            if (press_accept_c) begin
                ped_req <= 1'b1;
                overrun <= ped_req && !ped_ack;
                if (press_count != CNT_MAX) begin
                    press_count <= press_count + CNT_W'(1);
                end
            end else if (ped_req && ped_ack) begin
                ped_req <= 1'b0;
            end
        end
    end

endmodule
